// File: rtl/instr_buffer_if.sv
// Fetch/dispatch-side bundle for the decoded-instruction buffer.
// The master modport drives the fetch and dispatch inputs; the slave modport is the buffer itself.
interface instr_buffer_if #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENTRY_W = 39,
  parameter int unsigned DEQ_W   = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                     flush;
  logic [2:0]               in_count;
  logic [4*ENTRY_W-1:0]     in_entries_flat;
  logic [2:0]               num_fetch;
  logic [DEQ_W*ENTRY_W-1:0] out_entries_flat;
  logic [2:0]               out_count;
  logic [2:0]               deq_count;
  logic [CNT_W-1:0]         count;
  logic                     halted;

  modport master (
    output flush, in_count, in_entries_flat, deq_count,
    input  num_fetch, out_entries_flat, out_count, count, halted
  );

  modport slave (
    input  flush, in_count, in_entries_flat, deq_count,
    output num_fetch, out_entries_flat, out_count, count, halted
  );
endinterface

// File: rtl/instr_buffer.sv
// Circular instruction buffer between decode and dispatch: up to 4 enqueues and up to DEQ_W dequeues
// per cycle, with flush, sticky halt, and optional performance counters behind IBUF_PERF_CNT_EN.
module instr_buffer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENTRY_W = 39,
  parameter int unsigned DEQ_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  instr_buffer_if.slave     bus
`ifdef IBUF_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       enq_total
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   occ;
  logic               halted_q;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]   free_c;
  logic [2:0]         num_fetch_c;
  logic [2:0]         out_count_c;
  logic [2:0]         enq_lim_c;
  logic [2:0]         enq_c;
  logic [2:0]         deq_c;
  logic               halt_seen_c;

  // Admission control: clamp to free space, then cut the group just after the first halt.
  always_comb begin
    free_c      = CNT_W'(DEPTH) - occ;
    num_fetch_c = 3'd0;
    if (!halted_q) begin
      num_fetch_c = (free_c >= CNT_W'(4)) ? 3'd4 : 3'(free_c);
    end
    out_count_c = (occ >= CNT_W'(DEQ_W)) ? 3'(DEQ_W) : 3'(occ);
    enq_lim_c   = (bus.in_count < num_fetch_c) ? bus.in_count : num_fetch_c;
    enq_c       = enq_lim_c;
    halt_seen_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!halt_seen_c && (3'(k) < enq_lim_c) && bus.in_entries_flat[(3-k)*ENTRY_W]) begin
        enq_c       = 3'(k + 1);
        halt_seen_c = 1'b1;
      end
    end
    deq_c = (bus.deq_count < out_count_c) ? bus.deq_count : out_count_c;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      halted_q <= 1'b0;
    end else begin
      tail <= tail + PTR_W'(enq_c);
      head <= head + PTR_W'(deq_c);
      occ  <= occ + CNT_W'(enq_c) - CNT_W'(deq_c);
      if (halt_seen_c) begin
        halted_q <= 1'b1;
      end
    end
  end

  // Entry RAM is not reset; a group may straddle the end of the array.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < enq_c) begin
          mem[IDX_W'(tail) + IDX_W'(k)] <= bus.in_entries_flat[(3-k)*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  always_comb begin
    bus.out_entries_flat = '0;
    for (int j = 0; j < int'(DEQ_W); j++) begin
      bus.out_entries_flat[(int'(DEQ_W)-1-j)*ENTRY_W +: ENTRY_W] = mem[IDX_W'(head) + IDX_W'(j)];
    end
  end

  assign bus.num_fetch = num_fetch_c;
  assign bus.out_count = out_count_c;
  assign bus.count     = occ;
  assign bus.halted    = halted_q;

`ifdef IBUF_PERF_CNT_EN
  logic [16:0] enq_sum_c;
  assign enq_sum_c = {1'b0, enq_total} + 17'(enq_c);

  // Saturating counters; flush deliberately leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      enq_total    <= '0;
    end else begin
      if (num_fetch_c == 3'd0 && !halted_q && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      enq_total <= enq_sum_c[16] ? 16'hFFFF : enq_sum_c[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer: reset, fill, wrap drain, halt, flush, over-dequeue.
module tb_instr_buffer;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ENTRY_W = 39;
  localparam int unsigned DEQ_W   = 2;

  logic clk;
  logic rst;

  instr_buffer_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .DEQ_W(DEQ_W)) bus ();

`ifdef IBUF_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] enq_total;
`endif

  instr_buffer #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .DEQ_W(DEQ_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef IBUF_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .enq_total    (enq_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [ENTRY_W-1:0] q[$];
  logic [ENTRY_W-1:0] grp[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input logic [3:0] op, input logic [7:0] imm);
    logic [ENTRY_W-1:0] e;
    e    = {op, imm, imm[3:0], imm[3:0], imm[3:0], 15'd0};
    e[0] = (op == 4'd15);
    return e;
  endfunction

  function automatic logic [ENTRY_W-1:0] slot(input int j);
    return bus.out_entries_flat[(int'(DEQ_W)-1-j)*ENTRY_W +: ENTRY_W];
  endfunction

  task automatic drive(input int n);
    for (int k = 0; k < 4; k++) bus.in_entries_flat[(3-k)*ENTRY_W +: ENTRY_W] = grp[k];
    bus.in_count = 3'(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input int n);
    for (int j = 0; j < n; j++) check(tag, 64'(slot(j)), 64'(q[j]));
  endtask

  initial begin
    int exp_cnt;
    int next_imm;
    int nf;
    int enq;
    int oc;

    rst                 = 1'b1;
    bus.flush           = 1'b0;
    bus.in_count        = 3'd0;
    bus.in_entries_flat = '0;
    bus.deq_count       = 3'd0;
    for (int k = 0; k < 4; k++) grp[k] = '0;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    check("rst_num_fetch", 64'(bus.num_fetch), 64'd4);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_count",     64'(bus.count),     64'd0);
    check("rst_halted",    64'(bus.halted),    64'd0);

    // Fill with four groups of four
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        grp[k] = mk(4'd1, 8'(g*4 + k));
        q.push_back(grp[k]);
      end
      check("fill_num_fetch", 64'(bus.num_fetch), 64'd4);
      drive(4);
      step();
      check("fill_count", 64'(bus.count), 64'((g + 1) * 4));
    end
    check("full_num_fetch", 64'(bus.num_fetch), 64'd0);
    for (int k = 0; k < 4; k++) grp[k] = mk(4'd1, 8'(100 + k));
    drive(4);
    step();
    bus.in_count = 3'd0;
    check("drop_count",     64'(bus.count),     64'd16);
    check("full_out_count", 64'(bus.out_count), 64'd2);
    check_head("full_head", 2);

    // Drain two per cycle while refilling up to two, across the pointer wrap
    exp_cnt  = 16;
    next_imm = 16;
    for (int c = 0; c < 20; c++) begin
      nf  = (exp_cnt >= 12) ? 16 - exp_cnt : 4;
      enq = (nf < 2) ? nf : 2;
      oc  = (exp_cnt < 2) ? exp_cnt : 2;
      check("wrap_num_fetch", 64'(bus.num_fetch), 64'(nf));
      check("wrap_out_count", 64'(bus.out_count), 64'(oc));
      check_head("wrap_head", oc);
      for (int k = 0; k < 4; k++) grp[k] = mk(4'd6, 8'(next_imm + k));
      drive(enq);
      bus.deq_count = 3'd2;
      step();
      for (int k = 0; k < oc; k++) void'(q.pop_front());
      for (int k = 0; k < enq; k++) q.push_back(grp[k]);
      next_imm += enq;
      exp_cnt  = exp_cnt + enq - oc;
      check("wrap_count", 64'(bus.count), 64'(exp_cnt));
    end
    bus.in_count  = 3'd0;
    bus.deq_count = 3'd0;

    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    q.delete();
    check("flush_count",     64'(bus.count),     64'd0);
    check("flush_num_fetch", 64'(bus.num_fetch), 64'd4);
    check("flush_out_count", 64'(bus.out_count), 64'd0);

    // Halt truncation: ADD, HALT, SUB, LD keeps only the first two
    grp[0] = mk(4'd1, 8'd200);
    grp[1] = mk(4'd15, 8'd201);
    grp[2] = mk(4'd2, 8'd202);
    grp[3] = mk(4'd3, 8'd203);
    q.push_back(grp[0]);
    q.push_back(grp[1]);
    drive(4);
    step();
    check("halt_count",     64'(bus.count),     64'd2);
    check("halt_halted",    64'(bus.halted),    64'd1);
    check("halt_num_fetch", 64'(bus.num_fetch), 64'd0);
    check_head("halt_head", 2);
    step();
    check("halt_hold_count", 64'(bus.count), 64'd2);
    bus.in_count  = 3'd0;
    bus.deq_count = 3'd1;
    step();
    bus.deq_count = 3'd0;
    void'(q.pop_front());
    check("halt_deq_count",  64'(bus.count),     64'd1);
    check("halt_deq_halted", 64'(bus.halted),    64'd1);
    check("halt_deq_oc",     64'(bus.out_count), 64'd1);
    check_head("halt_deq_head", 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    q.delete();
    check("halt_flush_halted", 64'(bus.halted),    64'd0);
    check("halt_flush_nf",     64'(bus.num_fetch), 64'd4);
    check("halt_flush_count",  64'(bus.count),     64'd0);

    // Flush beats a same-cycle enqueue and dequeue
    for (int k = 0; k < 4; k++) grp[k] = mk(4'd4, 8'(10 + k));
    drive(4);
    step();
    for (int k = 0; k < 4; k++) grp[k] = mk(4'd4, 8'(14 + k));
    drive(2);
    step();
    check("pre_flush_count", 64'(bus.count), 64'd6);
    for (int k = 0; k < 4; k++) grp[k] = mk(4'd4, 8'(20 + k));
    drive(3);
    bus.deq_count = 3'd2;
    bus.flush     = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.in_count  = 3'd0;
    bus.deq_count = 3'd0;
    check("fprio_count",     64'(bus.count),     64'd0);
    check("fprio_out_count", 64'(bus.out_count), 64'd0);
    check("fprio_num_fetch", 64'(bus.num_fetch), 64'd4);
    step();
    check("fprio_idle_count", 64'(bus.count), 64'd0);

    // Over-dequeue is clamped to occupancy
    grp[0] = mk(4'd5, 8'd77);
    drive(1);
    step();
    bus.in_count = 3'd0;
    check("odeq_pre_count", 64'(bus.count),     64'd1);
    check("odeq_pre_oc",    64'(bus.out_count), 64'd1);
    check("odeq_slot0",     64'(slot(0)),       64'(mk(4'd5, 8'd77)));
    bus.deq_count = 3'd2;
    step();
    bus.deq_count = 3'd0;
    check("odeq_count", 64'(bus.count),     64'd0);
    check("odeq_oc",    64'(bus.out_count), 64'd0);

`ifdef IBUF_PERF_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_rst_stall", 64'(stall_cycles), 64'd0);
    check("perf_rst_enq",   64'(enq_total),    64'd0);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) grp[k] = mk(4'd7, 8'(g*4 + k));
      drive(4);
      step();
    end
    bus.in_count = 3'd0;
    for (int c = 0; c < 10; c++) step();
    check("perf_stall",     64'(stall_cycles), 64'd10);
    check("perf_enq_total", 64'(enq_total),    64'd16);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    check("perf_flush_stall", 64'(stall_cycles), 64'd11);
    check("perf_flush_enq",   64'(enq_total),    64'd16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
